retire_scheduler: RTL and testbench

RETIRE_SCHEDULER -- requirements
Module: retire_scheduler

---
 rtl/retire_scheduler_pkg.sv | 21 ++
 rtl/retire_scheduler.sv | 126 ++++++++++++
 tb/tb_retire_scheduler.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/retire_scheduler_pkg.sv
// Shared core package for the rename/retire slice.
// Holds the architectural register and physical tag counts, their index
// widths, and the packed in-flight entry layout used by the retire queue.
// No ports; imported by retire_scheduler and by rename.
package retire_scheduler_pkg;

  localparam int NUM_REG  = 32;
  localparam int NUM_TAGS = 64;
  localparam int REG_W    = $clog2(NUM_REG);
  localparam int TAG_W    = $clog2(NUM_TAGS);

  // One in-flight instruction. Tag 0 means "no destination", so such an
  // entry is born already done.
  typedef struct packed {
    logic             valid;
    logic             done;
    logic [TAG_W-1:0] tag;
    logic [REG_W-1:0] rd;
  } entry_t;

endpackage

// File: rtl/retire_scheduler.sv
// retire_scheduler
// In-order retirement queue. Rename allocates entries at the tail, execution
// ports mark them done by physical tag, and up to two finished entries leave
// from the head each cycle while rename is ready to accept them.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   alloc_valid/tag/reg      renamed instruction from rename
//   alloc_ready              queue has a free entry
//   complete_valid/tag [1:0] execution-complete strobes, one per port
//   retire_ready             rename accepts retirements this cycle
//   retire_valid/tag/reg     retiring slots (slot 1 only with slot 0)
//   count, empty             occupancy
module retire_scheduler #(
  parameter int NUM_REG  = retire_scheduler_pkg::NUM_REG,
  parameter int NUM_TAGS = retire_scheduler_pkg::NUM_TAGS,
  parameter int DEPTH    = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    alloc_valid,
  input  logic [$clog2(NUM_TAGS)-1:0]             alloc_tag,
  input  logic [$clog2(NUM_REG)-1:0]              alloc_reg,
  output logic                                    alloc_ready,
  input  logic [1:0]                              complete_valid,
  input  logic [1:0][$clog2(NUM_TAGS)-1:0]        complete_tag,
  input  logic                                    retire_ready,
  output logic [1:0]                              retire_valid,
  output logic [1:0][$clog2(NUM_TAGS)-1:0]        retire_tag,
  output logic [1:0][$clog2(NUM_REG)-1:0]         retire_reg,
  output logic [$clog2(DEPTH):0]                  count,
  output logic                                    empty
);

  import retire_scheduler_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t             q [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [PTR_W-1:0]   head1;
  logic               rv0;
  logic               rv1;
  logic               alloc_fire;
  logic [1:0]         retire_cnt;
  logic [DEPTH-1:0]   done_hit;
  logic [DEPTH-1:0]   retire_hit;

  // Head pair selection. Pointer width equals log2(DEPTH), so the +1
  // wraps modulo DEPTH on its own. Slot 1 can only go if slot 0 goes,
  // which keeps the retire stream strictly in order.
  assign head1       = head + PTR_W'(1);
  assign rv0         = retire_ready & q[head].valid & q[head].done;
  assign rv1         = rv0 & q[head1].valid & q[head1].done;
  assign retire_cnt  = {1'b0, rv0} + {1'b0, rv1};

  // Full-ness alone gates allocation; a retirement in the same cycle does
  // not open a slot until the next cycle.
  assign alloc_ready = (count < CNT_W'(DEPTH));
  assign alloc_fire  = alloc_valid & alloc_ready;
  assign empty       = (count == '0);

  // Retire outputs are zeroed on idle slots so downstream never sees stale
  // tags.
  always_comb begin
    retire_valid = {rv1, rv0};
    retire_tag   = '0;
    retire_reg   = '0;
    if (rv0) begin
      retire_tag[0] = q[head].tag;
      retire_reg[0] = q[head].rd;
    end
    if (rv1) begin
      retire_tag[1] = q[head1].tag;
      retire_reg[1] = q[head1].rd;
    end
  end

  // Per-entry parallel compare against both completion ports. Only entries
  // already valid can match, so an entry being written this cycle is never
  // marked done by a same-cycle completion. Tag 0 never matches. Both
  // ports carrying the same tag simply OR together.
  always_comb begin
    done_hit   = '0;
    retire_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      done_hit[i] = q[i].valid && (q[i].tag != '0) &&
                    ((complete_valid[0] && (q[i].tag == complete_tag[0])) ||
                     (complete_valid[1] && (q[i].tag == complete_tag[1])));
      retire_hit[i] = (rv0 && (head == PTR_W'(i))) ||
                      (rv1 && (head1 == PTR_W'(i)));
    end
  end

  // Queue state. A retiring entry can never be the tail being written: the
  // tail slot is empty whenever allocation is allowed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (retire_hit[i]) begin
          q[i] <= '0;
        end else if (alloc_fire && (tail == PTR_W'(i))) begin
          q[i].valid <= 1'b1;
          q[i].done  <= (alloc_tag == '0);
          q[i].tag   <= alloc_tag;
          q[i].rd    <= alloc_reg;
        end else if (done_hit[i]) begin
          q[i].done <= 1'b1;
        end
      end
      head  <= head + PTR_W'(retire_cnt);
      tail  <= tail + PTR_W'(alloc_fire);
      count <= count + CNT_W'(alloc_fire) - CNT_W'(retire_cnt);
    end
  end

endmodule

// File: tb/tb_retire_scheduler.sv
// tb_retire_scheduler
// Directed bench for retire_scheduler: fill/refuse at full, out-of-order
// completion with paired retire, tag-0 store, retire+alloc at full,
// pointer wrap-around with an in-order scoreboard, and mid-flight reset.
module tb_retire_scheduler;

  localparam int TW = 6;
  localparam int RW = 5;
  localparam int CW = 5;

  logic                 clk;
  logic                 rst;
  logic                 alloc_valid;
  logic [TW-1:0]        alloc_tag;
  logic [RW-1:0]        alloc_reg;
  logic                 alloc_ready;
  logic [1:0]           complete_valid;
  logic [1:0][TW-1:0]   complete_tag;
  logic                 retire_ready;
  logic [1:0]           retire_valid;
  logic [1:0][TW-1:0]   retire_tag;
  logic [1:0][RW-1:0]   retire_reg;
  logic [CW-1:0]        count;
  logic                 empty;

  int checks;
  int failures;
  int exp_tag [$];

  retire_scheduler #(.NUM_REG(32), .NUM_TAGS(64), .DEPTH(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .alloc_valid    (alloc_valid),
    .alloc_tag      (alloc_tag),
    .alloc_reg      (alloc_reg),
    .alloc_ready    (alloc_ready),
    .complete_valid (complete_valid),
    .complete_tag   (complete_tag),
    .retire_ready   (retire_ready),
    .retire_valid   (retire_valid),
    .retire_tag     (retire_tag),
    .retire_reg     (retire_reg),
    .count          (count),
    .empty          (empty)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case anything stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Single comparison point: counts every check, reports mismatches.
  task automatic checkOutput(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Drives every input for the coming cycle, then lets combinational
  // outputs settle so they can be checked right away.
  task automatic applyStimulus(input logic av, input int atag, input int areg,
                               input logic [1:0] cv, input int ct0, input int ct1,
                               input logic rr);
    alloc_valid     = av;
    alloc_tag       = TW'(atag);
    alloc_reg       = RW'(areg);
    complete_valid  = cv;
    complete_tag[0] = TW'(ct0);
    complete_tag[1] = TW'(ct1);
    retire_ready    = rr;
    #1;
  endtask

  // Advance one clock and sample 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int retired;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 0);
    tick();
    tick();

    checkOutput("rst_count", count, 0);
    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_alloc_ready", alloc_ready, 1);
    checkOutput("rst_retire_valid", retire_valid, 0);
    checkOutput("rst_retire_tag", retire_tag, 0);
    rst = 1'b0;

    // Fill with tags 32..47, reg = index.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 32 + i, i, 2'b00, 0, 0, 0);
      tick();
    end
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 0);
    checkOutput("full_count", count, 16);
    checkOutput("full_alloc_ready", alloc_ready, 0);

    // Seventeenth allocation is refused.
    applyStimulus(1, 50, 20, 2'b00, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 0);
    checkOutput("refuse_count", count, 16);

    // Head pair done, then retire two while allocating at full.
    applyStimulus(0, 0, 0, 2'b11, 32, 33, 0);
    checkOutput("no_retire_when_not_ready", retire_valid, 0);
    tick();
    applyStimulus(1, 60, 1, 2'b00, 0, 0, 1);
    checkOutput("full_pair_valid", retire_valid, 3);
    checkOutput("full_pair_tag0", retire_tag[0], 32);
    checkOutput("full_pair_tag1", retire_tag[1], 33);
    checkOutput("full_pair_alloc_ready", alloc_ready, 0);
    tick();
    checkOutput("after_pair_count", count, 14);
    checkOutput("after_pair_alloc_ready", alloc_ready, 1);
    tick();
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 0);
    checkOutput("after_alloc_count", count, 15);

    // Complete 34..47 and drain pairwise in order.
    for (int k = 0; k < 7; k++) begin
      applyStimulus(0, 0, 0, 2'b11, 34 + 2 * k, 35 + 2 * k, 0);
      tick();
    end
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 1);
    for (int k = 0; k < 7; k++) begin
      checkOutput("drain_valid", retire_valid, 3);
      checkOutput("drain_tag0", retire_tag[0], 34 + 2 * k);
      checkOutput("drain_tag1", retire_tag[1], 35 + 2 * k);
      checkOutput("drain_reg0", retire_reg[0], 2 + 2 * k);
      tick();
    end
    checkOutput("late_entry_not_done", retire_valid, 0);
    checkOutput("late_entry_count", count, 1);
    applyStimulus(0, 0, 0, 2'b01, 60, 0, 1);
    checkOutput("same_cycle_complete_no_retire", retire_valid, 0);
    tick();
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 1);
    checkOutput("late_valid", retire_valid, 1);
    checkOutput("late_tag", retire_tag[0], 60);
    checkOutput("late_reg", retire_reg[0], 1);
    checkOutput("late_slot1_tag_zero", retire_tag[1], 0);
    tick();
    checkOutput("drained_empty", empty, 1);

    // Out-of-order completion: 34 then 33, retire together.
    applyStimulus(1, 33, 5, 2'b00, 0, 0, 1);
    tick();
    applyStimulus(1, 34, 6, 2'b00, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 2'b01, 34, 0, 1);
    checkOutput("ooo_none_yet", retire_valid, 0);
    tick();
    applyStimulus(0, 0, 0, 2'b10, 0, 33, 1);
    checkOutput("ooo_young_done_only", retire_valid, 0);
    tick();
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 1);
    checkOutput("ooo_valid", retire_valid, 3);
    checkOutput("ooo_tag0", retire_tag[0], 33);
    checkOutput("ooo_tag1", retire_tag[1], 34);
    checkOutput("ooo_reg0", retire_reg[0], 5);
    checkOutput("ooo_reg1", retire_reg[1], 6);
    tick();
    checkOutput("ooo_empty", empty, 1);

    // Tag-0 store retires the cycle after allocation.
    applyStimulus(1, 0, 7, 2'b00, 0, 0, 1);
    checkOutput("store_not_before_alloc", retire_valid, 0);
    tick();
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 1);
    checkOutput("store_valid", retire_valid, 1);
    checkOutput("store_tag", retire_tag[0], 0);
    checkOutput("store_reg", retire_reg[0], 7);
    tick();
    checkOutput("store_count", count, 0);

    // Wrap-around: alloc each cycle, complete the previous one, retire.
    retired = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      logic av;
      logic [1:0] cv;
      av = (cyc < 40);
      cv = (cyc >= 1 && cyc <= 40) ? 2'b01 : 2'b00;
      if (av) exp_tag.push_back(cyc + 1);
      applyStimulus(av, cyc + 1, cyc % 32, cv, cyc, 0, 1);
      if (retire_valid == 2'b10) checkOutput("wrap_slot1_alone", retire_valid, 1);
      for (int s = 0; s < 2; s++) begin
        if (retire_valid[s]) begin
          if (exp_tag.size() == 0) begin
            checkOutput("wrap_unexpected_retire", retire_tag[s], -1);
          end else begin
            checkOutput("wrap_tag", retire_tag[s], exp_tag.pop_front());
          end
          retired++;
        end
      end
      tick();
    end
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 0);
    checkOutput("wrap_retired", retired, 40);
    checkOutput("wrap_count", count, 0);
    checkOutput("wrap_empty", empty, 1);

    // Mid-flight reset with retire_ready high.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 10 + i, i, 2'b00, 0, 0, 0);
      tick();
    end
    applyStimulus(0, 0, 0, 2'b11, 10, 11, 0);
    tick();
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 0);
    checkOutput("inflight_count", count, 5);
    retire_ready = 1'b1;
    #1;
    checkOutput("inflight_would_retire", retire_valid, 3);
    rst = 1'b1;
    #1;
    checkOutput("midrst_retire_valid", retire_valid, 0);
    checkOutput("midrst_count", count, 0);
    checkOutput("midrst_alloc_ready", alloc_ready, 1);
    checkOutput("midrst_retire_tag", retire_tag, 0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("post_rst_no_retire", retire_valid, 0);
    end
    checkOutput("post_rst_empty", empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
